// File: rtl/axi4_lite_pkg.sv
// -----------------------------------------------------------------------------
// axi4_lite_pkg
// Shared definitions for the AXI4-Lite register slave:
//   - AXI response codes (OKAY, SLVERR)
//   - write-channel and read-channel FSM state enums
//   - byte-lane mask helper used by the register write path
// No ports (package).
// -----------------------------------------------------------------------------
package axi4_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE      = 2'd0,
        W_HAVE_ADDR = 2'd1,
        W_HAVE_DATA = 2'd2,
        W_RESP      = 2'd3
    } wr_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_e;

    // Merge new data into an old 32-bit word under a 4-bit byte strobe.
    function automatic logic [31:0] strobe_merge(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [3:0]  strb
    );
        logic [31:0] res;
        res = old_word;
        for (int unsigned k = 0; k < 4; k++) begin
            if (strb[k]) begin
                res[8*k +: 8] = new_word[8*k +: 8];
            end
        end
        return res;
    endfunction

endpackage : axi4_lite_pkg

// File: rtl/axi4_lite_reg_slave.sv
// -----------------------------------------------------------------------------
// axi4_lite_reg_slave
// AXI4-Lite responder exposing NUM_REGS 32-bit registers at byte addresses
// 4*i (ADDR[1:0] ignored). Independent write and read FSMs run concurrently.
//
// Parameters:
//   ADDR_WIDTH  address width of AWADDR/ARADDR (default 32)
//   DATA_WIDTH  data / register width, only 32 supported (default 32)
//   NUM_REGS    number of registers, power of two 2..256 (default 16)
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   AWADDR/AWVALID/AWREADY   write address channel
//   WDATA/WSTRB/WVALID/WREADY write data channel
//   BRESP/BVALID/BREADY      write response channel
//   ARADDR/ARVALID/ARREADY   read address channel
//   RDATA/RRESP/RVALID/RREADY read data channel
//   regs_o                   flat register contents, reg i at [32i+31:32i]
//
// Build option:
//   AXIL_REG_SLAVE_ERR_EN  when defined, out-of-range accesses answer SLVERR;
//                          otherwise they answer OKAY. In both builds an
//                          out-of-range read returns 0 and a write is dropped.
// -----------------------------------------------------------------------------
module axi4_lite_reg_slave
    import axi4_lite_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_REGS   = 16
) (
    input  logic                           clk,
    input  logic                           rst,

    input  logic [ADDR_WIDTH-1:0]          AWADDR,
    input  logic                           AWVALID,
    output logic                           AWREADY,

    input  logic [DATA_WIDTH-1:0]          WDATA,
    input  logic [DATA_WIDTH/8-1:0]        WSTRB,
    input  logic                           WVALID,
    output logic                           WREADY,

    output logic [1:0]                     BRESP,
    output logic                           BVALID,
    input  logic                           BREADY,

    input  logic [ADDR_WIDTH-1:0]          ARADDR,
    input  logic                           ARVALID,
    output logic                           ARREADY,

    output logic [DATA_WIDTH-1:0]          RDATA,
    output logic [1:0]                     RRESP,
    output logic                           RVALID,
    input  logic                           RREADY,

    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);

    localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

`ifdef AXIL_REG_SLAVE_ERR_EN
    localparam logic [1:0] RESP_OOR = RESP_SLVERR;
`else
    localparam logic [1:0] RESP_OOR = RESP_OKAY;
`endif

    // ------------------------------------------------------------------
    // Address decode helpers
    // ------------------------------------------------------------------
    function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] a);
        // Everything above the register-index bits must be zero.
        return (a >> (IDX_W + 2)) == '0;
    endfunction

    function automatic logic [IDX_W-1:0] addr_index(input logic [ADDR_WIDTH-1:0] a);
        return a[IDX_W+1:2];
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    wr_state_e                 wr_state_q, wr_state_d;
    rd_state_e                 rd_state_q, rd_state_d;

    logic [ADDR_WIDTH-1:0]     awaddr_q,  awaddr_d;
    logic [DATA_WIDTH-1:0]     wdata_q,   wdata_d;
    logic [DATA_WIDTH/8-1:0]   wstrb_q,   wstrb_d;
    logic [1:0]                bresp_q,   bresp_d;

    logic [DATA_WIDTH-1:0]     rdata_q,   rdata_d;
    logic [1:0]                rresp_q,   rresp_d;

    logic [DATA_WIDTH-1:0]     regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0]     regs_d [NUM_REGS];

    // Commit bus: the address/data pair that completes on this edge.
    logic                      commit;
    logic [ADDR_WIDTH-1:0]     cm_addr;
    logic [DATA_WIDTH-1:0]     cm_data;
    logic [DATA_WIDTH/8-1:0]   cm_strb;

    logic                      aw_hs;
    logic                      w_hs;

    // ------------------------------------------------------------------
    // Channel handshake outputs (pure functions of FSM state)
    // ------------------------------------------------------------------
    assign AWREADY = (wr_state_q == W_IDLE) || (wr_state_q == W_HAVE_DATA);
    assign WREADY  = (wr_state_q == W_IDLE) || (wr_state_q == W_HAVE_ADDR);
    assign BVALID  = (wr_state_q == W_RESP);
    assign BRESP   = bresp_q;

    assign ARREADY = (rd_state_q == R_IDLE);
    assign RVALID  = (rd_state_q == R_DATA);
    assign RDATA   = rdata_q;
    assign RRESP   = rresp_q;

    assign aw_hs = AWVALID && AWREADY;
    assign w_hs  = WVALID  && WREADY;

    // ------------------------------------------------------------------
    // Write FSM: next state, holding registers, commit selection
    // ------------------------------------------------------------------
    always_comb begin
        wr_state_d = wr_state_q;
        awaddr_d   = awaddr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        bresp_d    = bresp_q;
        commit     = 1'b0;
        cm_addr    = awaddr_q;
        cm_data    = wdata_q;
        cm_strb    = wstrb_q;

        unique case (wr_state_q)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    commit     = 1'b1;
                    cm_addr    = AWADDR;
                    cm_data    = WDATA;
                    cm_strb    = WSTRB;
                    wr_state_d = W_RESP;
                end else if (aw_hs) begin
                    awaddr_d   = AWADDR;
                    wr_state_d = W_HAVE_ADDR;
                end else if (w_hs) begin
                    wdata_d    = WDATA;
                    wstrb_d    = WSTRB;
                    wr_state_d = W_HAVE_DATA;
                end
            end
            W_HAVE_ADDR: begin
                if (w_hs) begin
                    commit     = 1'b1;
                    cm_data    = WDATA;
                    cm_strb    = WSTRB;
                    wr_state_d = W_RESP;
                end
            end
            W_HAVE_DATA: begin
                if (aw_hs) begin
                    commit     = 1'b1;
                    cm_addr    = AWADDR;
                    wr_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (BREADY) begin
                    wr_state_d = W_IDLE;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase

        if (commit) begin
            bresp_d = addr_in_range(cm_addr) ? RESP_OKAY : RESP_OOR;
        end
    end

    // ------------------------------------------------------------------
    // Register array next state: byte-lane merge on an in-range commit
    // ------------------------------------------------------------------
    always_comb begin
        regs_d = regs_q;
        if (commit && addr_in_range(cm_addr)) begin
            regs_d[addr_index(cm_addr)] =
                strobe_merge(regs_q[addr_index(cm_addr)], cm_data, cm_strb);
        end
    end

    // ------------------------------------------------------------------
    // Read FSM. Data is captured from regs_q (not regs_d), so a read on the
    // same edge as a commit to the same register returns the old value.
    // ------------------------------------------------------------------
    always_comb begin
        rd_state_d = rd_state_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;

        unique case (rd_state_q)
            R_IDLE: begin
                if (ARVALID) begin
                    if (addr_in_range(ARADDR)) begin
                        rdata_d = regs_q[addr_index(ARADDR)];
                        rresp_d = RESP_OKAY;
                    end else begin
                        rdata_d = '0;
                        rresp_d = RESP_OOR;
                    end
                    rd_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (RREADY) begin
                    rd_state_d = R_IDLE;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state_q <= W_IDLE;
            rd_state_q <= R_IDLE;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bresp_q    <= '0;
            rdata_q    <= '0;
            rresp_q    <= '0;
            regs_q     <= '{default: '0};
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
            awaddr_q   <= awaddr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            bresp_q    <= bresp_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            regs_q     <= regs_d;
        end
    end

    // ------------------------------------------------------------------
    // Flattened register view
    // ------------------------------------------------------------------
    always_comb begin
        regs_o = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            regs_o[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
        end
    end

endmodule : axi4_lite_reg_slave

// File: tb/tb_axi4_lite_reg_slave.sv
// -----------------------------------------------------------------------------
// tb_axi4_lite_reg_slave
// Self-checking bench for axi4_lite_reg_slave (NUM_REGS = 16). Directed
// scenarios followed by randomized reads/writes checked against a simple
// array model of the register file.
// -----------------------------------------------------------------------------
module tb_axi4_lite_reg_slave;

    localparam int NREG = 16;

`ifdef AXIL_REG_SLAVE_ERR_EN
    localparam logic [1:0] EXP_OOR = 2'b10;
`else
    localparam logic [1:0] EXP_OOR = 2'b00;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [31:0]       AWADDR;
    logic              AWVALID;
    logic              AWREADY;
    logic [31:0]       WDATA;
    logic [3:0]        WSTRB;
    logic              WVALID;
    logic              WREADY;
    logic [1:0]        BRESP;
    logic              BVALID;
    logic              BREADY;
    logic [31:0]       ARADDR;
    logic              ARVALID;
    logic              ARREADY;
    logic [31:0]       RDATA;
    logic [1:0]        RRESP;
    logic              RVALID;
    logic              RREADY;
    logic [NREG*32-1:0] regs_o;

    logic [31:0] model [NREG];
    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    axi4_lite_reg_slave #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .NUM_REGS  (NREG)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .AWADDR (AWADDR),
        .AWVALID(AWVALID),
        .AWREADY(AWREADY),
        .WDATA  (WDATA),
        .WSTRB  (WSTRB),
        .WVALID (WVALID),
        .WREADY (WREADY),
        .BRESP  (BRESP),
        .BVALID (BVALID),
        .BREADY (BREADY),
        .ARADDR (ARADDR),
        .ARVALID(ARVALID),
        .ARREADY(ARREADY),
        .RDATA  (RDATA),
        .RRESP  (RRESP),
        .RVALID (RVALID),
        .RREADY (RREADY),
        .regs_o (regs_o)
    );

    // ---------------- reference model helpers ----------------
    function automatic bit in_rng(input logic [31:0] a);
        return a < 32'(4 * NREG);
    endfunction

    function automatic logic [31:0] byte_mask(input logic [3:0] s);
        logic [31:0] m;
        m = 32'h0;
        for (int k = 0; k < 4; k++) if (s[k]) m = m | (32'hFF << (8 * k));
        return m;
    endfunction

    function automatic logic [31:0] exp_read(input logic [31:0] a);
        return in_rng(a) ? model[a / 4] : 32'h0;
    endfunction

    function automatic logic [1:0] exp_resp(input logic [31:0] a);
        return in_rng(a) ? 2'b00 : EXP_OOR;
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] m;
        m = byte_mask(s);
        if (in_rng(a)) model[a / 4] = (model[a / 4] & ~m) | (d & m);
    endtask

    task automatic model_clear();
        for (int i = 0; i < NREG; i++) model[i] = 32'h0;
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < NREG; i++) begin
            check($sformatf("%s reg%0d", tag, i), regs_o[i*32 +: 32], model[i]);
        end
    endtask

    // ---------------- bus tasks ----------------
    // AW presented after aw_dly cycles, W after w_dly cycles, BREADY held low
    // for b_dly cycles once BVALID is seen.
    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int aw_dly, input int w_dly, input int b_dly);
        bit aw_done = 0;
        bit w_done  = 0;
        bit hs_aw, hs_w;
        int cyc = 0;
        while (!(aw_done && w_done) && cyc < 40) begin
            @(negedge clk);
            AWADDR  = a;
            WDATA   = d;
            WSTRB   = s;
            AWVALID = !aw_done && (cyc >= aw_dly);
            WVALID  = !w_done && (cyc >= w_dly);
            if (w_done && !aw_done) begin
                check("wready low in have_data", {31'h0, WREADY}, 32'h0);
                check("awready high in have_data", {31'h0, AWREADY}, 32'h1);
            end
            if (aw_done && !w_done) begin
                check("awready low in have_addr", {31'h0, AWREADY}, 32'h0);
            end
            hs_aw = AWVALID && AWREADY;
            hs_w  = WVALID && WREADY;
            @(posedge clk);
            aw_done = aw_done || hs_aw;
            w_done  = w_done || hs_w;
            cyc++;
        end
        if (!(aw_done && w_done)) check("write handshake timeout", 32'h0, 32'h1);
        @(negedge clk);
        AWVALID = 1'b0;
        WVALID  = 1'b0;
        model_write(a, d, s);
        check("bvalid after commit", {31'h0, BVALID}, 32'h1);
        check("bresp", {30'h0, BRESP}, {30'h0, exp_resp(a)});
        check("ready low in resp", {30'h0, AWREADY, WREADY}, 32'h0);
        for (int i = 0; i < b_dly; i++) begin
            @(negedge clk);
            check("bvalid held", {31'h0, BVALID}, 32'h1);
            check("bresp held", {30'h0, BRESP}, {30'h0, exp_resp(a)});
        end
        BREADY = 1'b1;
        @(posedge clk);
        @(negedge clk);
        BREADY = 1'b0;
        check("bvalid dropped", {31'h0, BVALID}, 32'h0);
        check("w ready restored", {30'h0, AWREADY, WREADY}, 32'h3);
        check_regs("after write");
    endtask

    task automatic axi_read(input logic [31:0] a, input int ar_dly, input int r_dly);
        logic [31:0] ed;
        logic [1:0]  er;
        bit done = 0;
        bit hs;
        int cyc = 0;
        ed = exp_read(a);
        er = exp_resp(a);
        while (!done && cyc < 40) begin
            @(negedge clk);
            ARADDR  = a;
            ARVALID = (cyc >= ar_dly);
            hs = ARVALID && ARREADY;
            @(posedge clk);
            done = hs;
            cyc++;
        end
        if (!done) check("read handshake timeout", 32'h0, 32'h1);
        @(negedge clk);
        ARVALID = 1'b0;
        check("rvalid", {31'h0, RVALID}, 32'h1);
        check("rdata", RDATA, ed);
        check("rresp", {30'h0, RRESP}, {30'h0, er});
        for (int i = 0; i < r_dly; i++) begin
            @(negedge clk);
            check("rvalid held", {31'h0, RVALID}, 32'h1);
            check("rdata held", RDATA, ed);
            check("arready low", {31'h0, ARREADY}, 32'h0);
        end
        RREADY = 1'b1;
        @(posedge clk);
        @(negedge clk);
        RREADY = 1'b0;
        check("rvalid dropped", {31'h0, RVALID}, 32'h0);
        check("arready restored", {31'h0, ARREADY}, 32'h1);
    endtask

    task automatic check_idle_after_reset(input string tag);
        check({tag, " awready"}, {31'h0, AWREADY}, 32'h1);
        check({tag, " wready"},  {31'h0, WREADY},  32'h1);
        check({tag, " arready"}, {31'h0, ARREADY}, 32'h1);
        check({tag, " bvalid"},  {31'h0, BVALID},  32'h0);
        check({tag, " rvalid"},  {31'h0, RVALID},  32'h0);
        check({tag, " bresp"},   {30'h0, BRESP},   32'h0);
        check({tag, " rresp"},   {30'h0, RRESP},   32'h0);
        check({tag, " rdata"},   RDATA,            32'h0);
        check_regs(tag);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] a, d, old_val;
        logic [3:0]  s;

        rst = 1'b1;
        AWADDR = '0; AWVALID = 1'b0;
        WDATA = '0; WSTRB = '0; WVALID = 1'b0;
        BREADY = 1'b0;
        ARADDR = '0; ARVALID = 1'b0;
        RREADY = 1'b0;
        model_clear();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_idle_after_reset("reset");

        // AW and W together at 0x08, BREADY ready at once.
        axi_write(32'h08, 32'hDEADBEEF, 4'hF, 0, 0, 0);
        check("reg2 deadbeef", regs_o[95:64], 32'hDEADBEEF);

        // W two cycles before AW, partial strobe.
        axi_write(32'h04, 32'h11223344, 4'h5, 2, 0, 0);
        check("reg1 strobe merge", regs_o[63:32], 32'h00220044);

        // AW before W, BREADY stalled.
        axi_write(32'h1C, 32'hCAFEF00D, 4'hA, 0, 3, 2);

        // Read with RREADY held low for three cycles.
        axi_read(32'h08, 0, 3);

        // Out-of-range read and write.
        axi_read(32'h40, 0, 0);
        axi_write(32'h40, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
        axi_read(32'h3F, 1, 0);

        // Same-edge write commit and read to 0x0C.
        axi_write(32'h0C, 32'h12345678, 4'hF, 0, 0, 0);
        old_val = model[3];
        @(negedge clk);
        AWADDR = 32'h0C; WDATA = 32'hA5A5A5A5; WSTRB = 4'hF;
        AWVALID = 1'b1; WVALID = 1'b1;
        ARADDR = 32'h0C; ARVALID = 1'b1;
        @(posedge clk);
        @(negedge clk);
        AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
        model_write(32'h0C, 32'hA5A5A5A5, 4'hF);
        check("same-edge rvalid", {31'h0, RVALID}, 32'h1);
        check("same-edge old value", RDATA, old_val);
        check("same-edge bvalid", {31'h0, BVALID}, 32'h1);
        BREADY = 1'b1; RREADY = 1'b1;
        @(posedge clk);
        @(negedge clk);
        BREADY = 1'b0; RREADY = 1'b0;
        axi_read(32'h0C, 0, 0);
        check("reg3 new value", regs_o[127:96], 32'hA5A5A5A5);

        // Reset while BVALID and RVALID pending, with W presented.
        @(negedge clk);
        AWADDR = 32'h10; WDATA = 32'h55AA55AA; WSTRB = 4'hF;
        AWVALID = 1'b1; WVALID = 1'b1;
        ARADDR = 32'h08; ARVALID = 1'b1;
        @(posedge clk);
        @(negedge clk);
        AWVALID = 1'b0; ARVALID = 1'b0;
        WDATA = 32'h77777777; WVALID = 1'b1;
        check("pre-reset bvalid", {31'h0, BVALID}, 32'h1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; WVALID = 1'b0;
        model_clear();
        check_idle_after_reset("mid reset");

        // Held W dropped by reset: AW alone afterwards must not commit.
        @(negedge clk);
        AWADDR = 32'h14; WDATA = 32'h99999999; WSTRB = 4'hF; WVALID = 1'b1;
        @(posedge clk);
        @(negedge clk);
        WVALID = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        AWVALID = 1'b1;
        @(posedge clk);
        @(negedge clk);
        AWVALID = 1'b0;
        check("no commit after dropped W", {31'h0, BVALID}, 32'h0);
        check("have_addr wready", {31'h0, WREADY}, 32'h1);
        check("have_addr awready", {31'h0, AWREADY}, 32'h0);
        check_regs("dropped W");
        WDATA = 32'h13572468; WSTRB = 4'h3; WVALID = 1'b1;
        @(posedge clk);
        @(negedge clk);
        WVALID = 1'b0;
        model_write(32'h14, 32'h13572468, 4'h3);
        check("complete after reset bvalid", {31'h0, BVALID}, 32'h1);
        BREADY = 1'b1;
        @(posedge clk);
        @(negedge clk);
        BREADY = 1'b0;
        check_regs("complete after reset");

        // Randomized traffic.
        for (int t = 0; t < 40; t++) begin
            a = 32'($urandom_range(0, 32'h4B));
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom;
                s = 4'($urandom_range(0, 15));
                axi_write(a, d, s, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2));
            end else begin
                axi_read(a, $urandom_range(0, 2), $urandom_range(0, 2));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_axi4_lite_reg_slave
